// File: rtl/mem_access_stage_if.sv
// Pipeline handshake bundle around the MEM stage: the EXE->MEM link
// (valid/bus in, allowin out) and the MEM->WB link (valid/bus out,
// allowin in). The slave modport is the MEM stage's view; the master
// modport is the view of the surrounding pipeline.
interface mem_access_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int MS_TO_WS_BUS_WD = 70
);
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;

    modport master (
        output es_to_ms_valid,
        output es_to_ms_bus,
        output ws_allowin,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus
    );

    modport slave (
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  ws_allowin,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage LA32 core. Holds one instruction from EXE,
// picks the write-back value (synchronous data-SRAM read data for loads,
// ALU result otherwise) and forwards it to WB. The SRAM read data is only
// valid in the first cycle after accept, so it is captured into a holding
// register to keep a load's value stable while WB stalls.
module mem_access_stage #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_stage_if.slave pipe,
    input  logic [31:0]       data_sram_rdata,
    output logic [4:0]        ms_to_ds_dest,
    output logic              ms_to_ds_load_op,
    output logic [31:0]       ms_to_ds_result
);
    logic                       ms_valid_r;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic                       ms_first_r;
    logic [31:0]                rdata_buf_r;

    logic                       ms_ready_go_s;
    logic                       ms_allowin_s;
    logic                       accept_s;
    logic                       res_from_mem_s;
    logic                       gr_we_s;
    logic [4:0]                 dest_s;
    logic [31:0]                alu_result_s;
    logic [31:0]                pc_s;
    logic [31:0]                mem_rdata_s;
    logic [31:0]                final_result_s;

    // Stage never needs extra cycles: memory access completes in the SRAM.
    assign ms_ready_go_s  = 1'b1;
    assign ms_allowin_s   = !ms_valid_r || (ms_ready_go_s && pipe.ws_allowin);
    assign accept_s       = pipe.es_to_ms_valid && ms_allowin_s;

    assign res_from_mem_s = bus_r[70];
    assign gr_we_s        = bus_r[69];
    assign dest_s         = bus_r[68:64];
    assign alu_result_s   = bus_r[63:32];
    assign pc_s           = bus_r[31:0];

    // SRAM data is live only on the first cycle; afterwards use the copy.
    assign mem_rdata_s    = ms_first_r ? data_sram_rdata : rdata_buf_r;
    assign final_result_s = res_from_mem_s ? mem_rdata_s : alu_result_s;

    assign pipe.ms_allowin     = ms_allowin_s;
    assign pipe.ms_to_ws_valid = ms_valid_r && ms_ready_go_s;
    assign pipe.ms_to_ws_bus   = {gr_we_s, dest_s, final_result_s, pc_s};

    assign ms_to_ds_dest    = dest_s & {5{ms_valid_r && gr_we_s}};
    assign ms_to_ds_load_op = ms_valid_r && res_from_mem_s;
    assign ms_to_ds_result  = final_result_s;

    // Occupancy: refilled (or emptied by a bubble) whenever the stage can take input.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin_s) begin
            ms_valid_r <= pipe.es_to_ms_valid;
        end else begin
            ms_valid_r <= ms_valid_r;
        end
    end

    // Payload register: loads only on a real accept so a stalled instruction stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_r <= {ES_TO_MS_BUS_WD{1'b0}};
        end else if (accept_s) begin
            bus_r <= pipe.es_to_ms_bus;
        end else begin
            bus_r <= bus_r;
        end
    end

    // First-cycle flag: marks the one cycle in which data_sram_rdata belongs to us.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_first_r <= 1'b0;
        end else begin
            ms_first_r <= accept_s;
        end
    end

    // Read-data holding register: snapshot the SRAM output on the first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_r <= 32'h0000_0000;
        end else if (ms_first_r) begin
            rdata_buf_r <= data_sram_rdata;
        end else begin
            rdata_buf_r <= rdata_buf_r;
        end
    end
endmodule
